// File: rtl/fir_filter_mac.sv
// ---------------------------------------------------------------------------
// fir_filter_mac
//
// Time-multiplexed FIR filter. Each accepted sample enters a TAPS-deep delay
// line, and one shared multiply-accumulate unit then steps over every tap,
// one tap per clock. The finished sum is formatted and presented on out_data
// together with a one-cycle out_valid strobe. Coefficients can be rewritten
// at run time, but only while the filter is idle. This keeps them stable for
// the whole of a computation.
//
// Optional build macro:
//   FIR_MAC_ROUND_SAT_EN  - round half-up before the output shift and
//                           saturate to the signed OUT_W range. Without it
//                           the output is a truncating shift that wraps.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   in_data     signed input sample (DATA_W)
//   in_valid    in_data is valid
//   in_ready    block can accept a sample this cycle (IDLE only)
//   coef_we     coefficient write strobe (honoured in IDLE only)
//   coef_addr   coefficient index
//   coef_wdata  signed coefficient value (COEF_W)
//   out_data    signed filter result (OUT_W), held until the next result
//   out_valid   single-cycle result strobe
//   busy        high while the MAC runs and during the result cycle
// ---------------------------------------------------------------------------
module fir_filter_mac #(
   parameter int TAPS   = 32,
   parameter int DATA_W = 10,
   parameter int COEF_W = 8,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
   parameter int OUT_W  = 17,
   parameter int SHIFT  = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_valid,
   output logic                     busy
);

   localparam int K_W   = $clog2(TAPS);
   localparam int P_W   = DATA_W + COEF_W;
   // One spare bit above the wider of accumulator/output, so that the
   // rounding add can never overflow the formatting arithmetic.
   localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t state;
   state_t state_next;

   logic signed [DATA_W-1:0] x [TAPS];
   logic signed [COEF_W-1:0] h [TAPS];
   logic [K_W-1:0]           k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [P_W-1:0]    prod;
   logic signed [EXT_W-1:0]  acc_ext;
   logic signed [EXT_W-1:0]  shifted;
   logic signed [OUT_W-1:0]  fmt_result;
   logic                     accept;

   assign accept = in_valid & in_ready;

   // The state register. An asynchronous reset drops any computation that is
   // in progress, so a result strobe can never follow a reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. in_ready is only high in IDLE. A
   // sample offered during MAC/DONE is therefore left with the source.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = MAC;
            end
         end
         MAC: begin
            busy = 1'b1;
            if (k == K_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            out_valid  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Delay line. x[0] always holds the newest accepted sample.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
         end
      end else if (state == IDLE && accept) begin
         x[0] <= in_data;
         for (int i = 1; i < TAPS; i++) begin
            x[i] <= x[i-1];
         end
      end
   end

   // Coefficient bank. It is writable only in IDLE, so a write that lands
   // together with a sample accept is already in place for that computation.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TAPS; i++) begin
            h[i] <= '0;
         end
      end else if (state == IDLE && coef_we && (int'(coef_addr) < TAPS)) begin
         h[coef_addr] <= coef_wdata;
      end
   end

   // Shared multiplier. Both operands are sign-extended to the product width
   // first. The product is then sign-extended again into the accumulator.
   always_comb begin
      prod    = P_W'(h[k]) * P_W'(x[k]);
      acc_sum = acc + ACC_W'(prod);
   end

`ifdef FIR_MAC_ROUND_SAT_EN
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [EXT_W-1:0] RND_ADD =
      (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

   // Output formatting: round half-up, shift arithmetically, then clamp to
   // the signed output range.
   always_comb begin
      acc_ext = EXT_W'(acc_sum);
      shifted = (acc_ext + RND_ADD) >>> SHIFT;
      if (shifted > SAT_MAX) begin
         fmt_result = OUT_W'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
         fmt_result = OUT_W'(SAT_MIN);
      end else begin
         fmt_result = OUT_W'(shifted);
      end
   end
`else
   // Output formatting: arithmetic shift, then keep the low OUT_W bits.
   // Out-of-range results wrap.
   always_comb begin
      acc_ext    = EXT_W'(acc_sum);
      shifted    = acc_ext >>> SHIFT;
      fmt_result = OUT_W'(shifted);
   end
`endif

   // MAC sequencing. The final tap's product goes straight into out_data
   // through acc_sum, so MAC lasts exactly TAPS cycles. k returns to 0 after
   // the last tap, so the multiplier never sees an index outside the arrays.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         k        <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= '0;
                  k   <= '0;
               end
            end
            MAC: begin
               acc <= acc_sum;
               if (k == K_LAST) begin
                  k        <= '0;
                  out_data <= fmt_result;
               end else begin
                  k <= k + K_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_mac
//
// Self-checking bench for fir_filter_mac with TAPS=4. A plain-arithmetic
// reference (a sample history plus coefficient array, summed and formatted)
// predicts every result. Two instances share all of the inputs:
//   dut   - SHIFT=0, OUT_W=17
//   dutF  - SHIFT=2, OUT_W=8 (exercises the shift/round/saturate formatting)
// ---------------------------------------------------------------------------
module tb_fir_filter_mac;

   localparam int TAPS    = 4;
   localparam int DATA_W  = 10;
   localparam int COEF_W  = 8;
   localparam int OUT_W   = 17;
   localparam int SHIFT   = 0;
   localparam int F_OUT_W = 8;
   localparam int F_SHIFT = 2;

   logic                      clock = 1'b0;
   logic                      reset;
   logic signed [DATA_W-1:0]  in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic                      coef_we;
   logic [1:0]                coef_addr;
   logic signed [COEF_W-1:0]  coef_wdata;
   logic signed [OUT_W-1:0]   out_data;
   logic                      out_valid;
   logic                      busy;
   logic                      f_in_ready;
   logic signed [F_OUT_W-1:0] f_out_data;
   logic                      f_out_valid;
   logic                      f_busy;

   int compared   = 0;
   int mismatched = 0;

   longint hModel [TAPS];
   longint xModel [TAPS];

   typedef struct {
      bit     doReset;
      int     coef [TAPS];
      int     sample;
      longint expected;
   } vec_t;

   vec_t vecs [8];

   fir_filter_mac #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_wdata(coef_wdata), .out_data(out_data), .out_valid(out_valid),
      .busy(busy)
   );

   fir_filter_mac #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(F_OUT_W), .SHIFT(F_SHIFT)
   ) dutF (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(f_in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_wdata(coef_wdata), .out_data(f_out_data), .out_valid(f_out_valid),
      .busy(f_busy)
   );

   always #5 clock = ~clock;

   // Reference model: y = sum h[k]*x[k], followed by the output formatting.
   function automatic longint modelSum();
      longint s = 0;
      for (int i = 0; i < TAPS; i++) begin
         s += hModel[i] * xModel[i];
      end
      return s;
   endfunction

   function automatic longint modelFmt(input longint a, input int sh, input int ow);
      longint v;
      longint lim;
`ifdef FIR_MAC_ROUND_SAT_EN
      if (sh > 0) a = a + (longint'(1) << (sh - 1));
      v   = a >>> sh;
      lim = (longint'(1) << (ow - 1)) - 1;
      if (v > lim) v = lim;
      if (v < -lim - 1) v = -lim - 1;
`else
      v   = a >>> sh;
      lim = longint'(1) << ow;
      v   = v & (lim - 1);
      if (v >= (lim >> 1)) v = v - lim;
`endif
      return v;
   endfunction

   function automatic void modelPush(input int sample);
      for (int i = TAPS - 1; i > 0; i--) begin
         xModel[i] = xModel[i-1];
      end
      xModel[0] = sample;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic resetDut();
      reset    = 1'b0;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      for (int i = 0; i < TAPS; i++) begin
         hModel[i] = 0;
         xModel[i] = 0;
      end
   endtask

   task automatic writeCoef(input int addr, input int val);
      coef_we    = 1'b1;
      coef_addr  = 2'(addr);
      coef_wdata = 8'(val);
      @(posedge clock);
      #1 coef_we = 1'b0;
      hModel[addr] = val;
   endtask

   // Waits (with a bound) for out_valid and returns both results and the
   // number of edges waited. It also checks that the strobe lasts one cycle.
   task automatic waitResult(output longint got, output longint gotF, output int lat);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clock);
         #1 n++;
      end
      checkOutput("out_valid seen", out_valid, 1);
      got  = out_data;
      gotF = f_out_data;
      lat  = n;
      @(posedge clock);
      #1;
      checkOutput("strobe then ready", {out_valid, in_ready}, 2'b01);
   endtask

   task automatic applyStimulus(input int sample, output longint got);
      int     n = 0;
      int     lat;
      longint gotF;
      while (!in_ready && n < 50) begin
         @(posedge clock);
         #1 n++;
      end
      checkOutput("in_ready before send", in_ready, 1);
      in_data  = 10'(sample);
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      modelPush(sample);
      waitResult(got, gotF, lat);
      checkOutput("latency", lat, TAPS);
      checkOutput("model y", got, modelFmt(modelSum(), SHIFT, OUT_W));
      checkOutput("model yF", gotF, modelFmt(modelSum(), F_SHIFT, F_OUT_W));
   endtask

   initial begin
      longint got;
      longint gotF;
      int     lat;
      int     pulses;
      int     accepts;
      int     lastAcc;
      int     readyWhileBusy;
      bit     took;
      longint expQ [$];
      int     bp [4];

      in_data    = '0;
      coef_addr  = '0;
      coef_wdata = '0;

      // ---- reset state ----
      resetDut();
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset busy", busy, 0);

      // ---- table vectors: impulse and signed step ----
      vecs[0] = '{1'b1, '{1, 2, 3, 4}, 1, 1};
      vecs[1] = '{1'b0, '{1, 2, 3, 4}, 0, 2};
      vecs[2] = '{1'b0, '{1, 2, 3, 4}, 0, 3};
      vecs[3] = '{1'b0, '{1, 2, 3, 4}, 0, 4};
      vecs[4] = '{1'b1, '{1, -2, 3, -4}, -5, -5};
      vecs[5] = '{1'b0, '{1, -2, 3, -4}, -5, 5};
      vecs[6] = '{1'b0, '{1, -2, 3, -4}, -5, -10};
      vecs[7] = '{1'b0, '{1, -2, 3, -4}, -5, 10};
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].doReset) resetDut();
         for (int i = 0; i < TAPS; i++) writeCoef(i, vecs[v].coef[i]);
         applyStimulus(vecs[v].sample, got);
         checkOutput("table y", got, vecs[v].expected);
      end

      // ---- reset in the middle of MAC ----
      for (int i = 0; i < TAPS; i++) writeCoef(i, 5 + i);
      applyStimulus(100, got);
      in_data  = 10'(37);
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      checkOutput("midreset out_data", out_data, 0);
      checkOutput("midreset f_out_data", f_out_data, 0);
      checkOutput("midreset out_valid", out_valid, 0);
      checkOutput("midreset in_ready", in_ready, 1);
      checkOutput("midreset busy", busy, 0);
      @(posedge clock);
      #1 reset = 1'b1;
      for (int i = 0; i < TAPS; i++) begin
         hModel[i] = 0;
         xModel[i] = 0;
      end
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) pulses++;
         @(posedge clock);
         #1;
      end
      checkOutput("no strobe after reset", pulses, 0);
      applyStimulus(77, got);
      checkOutput("cleared state result", got, 0);

      // ---- backpressure: in_valid held high ----
      for (int i = 0; i < TAPS; i++) writeCoef(i, i - 2);
      for (int i = 0; i < 4; i++) bp[i] = $urandom_range(0, 1023) - 512;
      accepts        = 0;
      lastAcc        = -1;
      readyWhileBusy = 0;
      in_data        = 10'(bp[0]);
      in_valid       = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (out_valid) begin
            if (expQ.size() > 0) checkOutput("bp result", out_data, expQ.pop_front());
            else checkOutput("bp spurious strobe", out_valid, 0);
         end
         if (busy && in_ready) readyWhileBusy++;
         took = in_valid && in_ready;
         if (took) begin
            modelPush(int'(in_data));
            expQ.push_back(modelFmt(modelSum(), SHIFT, OUT_W));
            if (lastAcc >= 0) checkOutput("bp spacing", c - lastAcc, TAPS + 2);
            lastAcc = c;
            accepts++;
         end
         @(posedge clock);
         #1;
         if (took) begin
            if (accepts < 4) in_data = 10'(bp[accepts]);
            else in_valid = 1'b0;
         end
      end
      checkOutput("bp accepts", accepts, 4);
      checkOutput("bp ready low while busy", readyWhileBusy, 0);
      checkOutput("bp results drained", expQ.size(), 0);

      // ---- coefficient write while busy is ignored ----
      for (int i = 0; i < TAPS; i++) writeCoef(i, 2 + i);
      in_data  = 10'(10);
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      modelPush(10);
      coef_we    = 1'b1;
      coef_addr  = 2'd0;
      coef_wdata = 8'(7);
      @(posedge clock);
      #1 coef_we = 1'b0;
      waitResult(got, gotF, lat);
      checkOutput("busy write ignored", got, modelFmt(modelSum(), SHIFT, OUT_W));
      writeCoef(0, 7);
      applyStimulus(3, got);
      checkOutput("idle write used", got, modelFmt(modelSum(), SHIFT, OUT_W));

      // ---- write and accept in the same IDLE cycle ----
      coef_we    = 1'b1;
      coef_addr  = 2'd1;
      coef_wdata = 8'(-3);
      in_data    = 10'(-20);
      in_valid   = 1'b1;
      @(posedge clock);
      #1;
      coef_we  = 1'b0;
      in_valid = 1'b0;
      hModel[1] = -3;
      modelPush(-20);
      waitResult(got, gotF, lat);
      checkOutput("same-cycle write y", got, modelFmt(modelSum(), SHIFT, OUT_W));
      checkOutput("same-cycle write latency", lat, TAPS);

      // ---- randomized samples and coefficients ----
      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            writeCoef($urandom_range(0, TAPS - 1), $urandom_range(0, 255) - 128);
         end
         applyStimulus($urandom_range(0, 1023) - 512, got);
      end

      // ---- formatting extremes: h all 127, four samples of 511 ----
      for (int i = 0; i < TAPS; i++) writeCoef(i, 127);
      for (int i = 0; i < 4; i++) begin
         in_data  = 10'(511);
         in_valid = 1'b1;
         @(posedge clock);
         #1 in_valid = 1'b0;
         modelPush(511);
         waitResult(got, gotF, lat);
      end
      checkOutput("full-scale sum y", got, modelFmt(longint'(259588), SHIFT, OUT_W));
`ifdef FIR_MAC_ROUND_SAT_EN
      checkOutput("saturated yF", gotF, 127);
`else
      checkOutput("wrapped yF", gotF, -127);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
- Parametrised, time-multiplexed successor to the fixed 32-tap FIR filter.
- Signed data and coefficients; coefficients loadable at run time through a write port.
- One shared multiply-accumulate unit, stepped over all taps per sample.
- Sits between the sample source and downstream DSP, with a valid/ready input and a valid-pulse output.

Parameters:
- TAPS, 32, number of taps (>=2).
- DATA_W, 10, input sample width, signed two's complement.
- COEF_W, 8, coefficient width, signed two's complement.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width; never overflows.
- OUT_W, 17, output width.
- SHIFT, 0, right shift applied to the accumulator before output (0 <= SHIFT < ACC_W).

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset; assert async, deassert sync to clock.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index k.
- coef_wdata  in  COEF_W  signed coefficient h[k].
- out_data  out  OUT_W  signed filter result.
- out_valid  out  1  single-cycle result strobe.
- busy  out  1  high in MAC or DONE.

Behaviour:
- Storage:
  - Delay line x[0..TAPS-1], where x[0] is the newest sample.
  - Coefficient bank h[0..TAPS-1].
- Reset (reset=0):
  - x[*]=0, h[*]=0, acc=0, state=IDLE.
  - out_data=0, out_valid=0, in_ready=1, busy=0.
  - Reset mid-operation aborts the computation; no out_valid is produced.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&in_ready: shift x[k]<=x[k-1] for k>=1, x[0]<=in_data, acc<=0, k<=0, go to MAC.
- MAC:
  - in_ready=0, busy=1.
  - Each cycle: acc<=acc+h[k]*x[k] as a signed product sign-extended to ACC_W; k<=k+1.
  - When k==TAPS-1: out_data<=fmt(acc+h[k]*x[k]), go to DONE.
  - MAC lasts exactly TAPS cycles.
- DONE:
  - out_valid=1 for this one cycle; in_ready=0, busy=1.
  - out_data holds until the next DONE.
  - Next state is IDLE.
- Latency and throughput:
  - Sample accepted at edge t → out_valid high during the cycle following edge t+TAPS.
  - Minimum sample spacing is TAPS+2 cycles.
  - in_valid while in_ready=0 is not consumed; the source holds data.
- Result: y = sum over k=0..TAPS-1 of h[k]*x[k], using the coefficient values at MAC time.
- Coefficient writes:
  - Take effect at the edge only when state==IDLE.
  - Writes in MAC or DONE are ignored, so coefficients are stable within a computation.
  - A write and a sample accept in the same IDLE cycle are both performed; the new coefficient is used by that computation.
- fmt() without the feature: (acc >>> SHIFT) truncated to the low OUT_W bits (wraps).
- k counter wraps to 0 on entry to MAC; no out-of-range index is ever used.

Optional Feature:
- Macro: FIR_MAC_ROUND_SAT_EN.
- Defined: fmt() adds 2^(SHIFT-1) before the arithmetic shift (round-half-up; no add when SHIFT=0), then saturates to OUT_W signed limits [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: truncating shift and wrap as above; no rounding or saturation logic is synthesised.

Test Plan:
- Reset: TAPS=4; drive reset low mid-MAC → out_data=0, out_valid never pulses, in_ready=1, and all h and x read back as 0 in the next computation (result 0).
- Impulse: TAPS=4, h={1,2,3,4}; send 1, 0, 0, 0 → outputs 1, 2, 3, 4; each out_valid is TAPS+1 cycles after its accept.
- Step, signed: TAPS=4, h={1,-2,3,-4}; send -5 four times → outputs -5, 5, -10, 10.
- Backpressure: hold in_valid=1 continuously → samples accepted exactly every TAPS+2 cycles; in_ready low throughout MAC and DONE.
- Coefficient write during MAC: write h[0]=7 while busy → ignored; result uses the old h[0]. Rewrite in IDLE → the next result uses 7.
- Feature: TAPS=4, SHIFT=2, OUT_W=8, h=all 127, four inputs of 511 → with FIR_MAC_ROUND_SAT_EN out_data=127; without it out_data equals the low 8 bits of (259588>>>2).
